// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the rx-echo source (0) and the local message
// source (1): fixed or round-robin grant, byte held for the frame, ack on completion.
module uart_tx_arbiter #(
   parameter int TIMEOUT = 200000,
   parameter int DW      = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          loopback_enable,
   input  logic          req0,
   input  logic [DW-1:0] data0,
   output logic          ack0,
   input  logic          req1,
   input  logic [DW-1:0] data1,
   output logic          ack1,
   output logic          tx_start,
   output logic [DW-1:0] tx_data,
   input  logic          tx_done,
   output logic          busy,
   output logic          grant_id,
   output logic          timeout_err
);

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE, ACK} state_t;

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic          last_reg;
   logic          grant_reg;
   logic          tx_start_reg;
   logic          busy_reg;
   logic          timeout_reg;
   logic [1:0]    ack_reg;
   logic [DW-1:0] tx_data_reg;
   logic          winner;

   // Round-robin favours the source not served last; last resets to 1 so source 0 wins the first tie.
   always_comb begin
      winner = 1'b0;
      if (loopback_enable)
         winner = ~req0;
      else if (req0 && req1)
         winner = ~last_reg;
      else
         winner = req1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         last_reg     <= 1'b1;
         grant_reg    <= 1'b0;
         tx_start_reg <= 1'b0;
         busy_reg     <= 1'b0;
         timeout_reg  <= 1'b0;
         ack_reg      <= 2'b00;
         tx_data_reg  <= '0;
      end else begin
         tx_start_reg <= 1'b0;
         timeout_reg  <= 1'b0;
         ack_reg      <= 2'b00;
         case (state_reg)
            IDLE: begin
               if (req0 || req1) begin
                  grant_reg    <= winner;
                  tx_data_reg  <= winner ? data1 : data0;
                  tx_start_reg <= 1'b1;
                  busy_reg     <= 1'b1;
                  state_reg    <= START;
               end
            end
            // A tx_done arriving here belongs to an earlier frame, so it is not looked at.
            START: begin
               cnt_reg   <= '0;
               state_reg <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (tx_done) begin
                  ack_reg   <= grant_reg ? 2'b10 : 2'b01;
                  state_reg <= ACK;
               end else if (cnt_reg == CNT_LAST) begin
                  timeout_reg <= 1'b1;
                  ack_reg     <= grant_reg ? 2'b10 : 2'b01;
                  state_reg   <= ACK;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            ACK: begin
               last_reg  <= grant_reg;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign ack0        = ack_reg[0];
   assign ack1        = ack_reg[1];
   assign tx_start    = tx_start_reg;
   assign tx_data     = tx_data_reg;
   assign busy        = busy_reg;
   assign grant_id    = grant_reg;
   assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected (source, byte) pairs are queued as
// requests are driven and retired against each ack pulse.
module tb_uart_tx_arbiter;

   logic       clk, rst_n, loopback_enable;
   logic       req0, req1, ack0, ack1;
   logic [7:0] data0, data1, tx_data;
   logic       tx_start, tx_done, busy, grant_id, timeout_err;

   uart_tx_arbiter #(.TIMEOUT(16), .DW(8)) dut (
      .clk(clk), .rst_n(rst_n), .loopback_enable(loopback_enable),
      .req0(req0), .data0(data0), .ack0(ack0),
      .req1(req1), .data1(data1), .ack1(ack1),
      .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
      .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       src;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Results of the most recent transfer driven by run_xfer.
   bit         r_ok, r_stable;
   logic       r_a0, r_a1, r_to;
   logic [7:0] r_data;
   int         r_ts, r_ta, r_nstart;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Plays the UART core: pulses tx_done dly cycles after tx_start (never if dly<=0),
   // optionally also in the tx_start cycle, and returns at the first ack.
   task automatic run_xfer(input int dly, input bit early);
      int cd;
      logic [7:0] d0;
      bit started;
      cd = 0; d0 = '0; started = 0;
      r_ok = 0; r_stable = 1; r_a0 = 0; r_a1 = 0; r_to = 0; r_data = '0;
      r_ts = -1; r_ta = -1; r_nstart = 0;
      for (int c = 1; c <= 100 && !r_ok; c++) begin
         step();
         tx_done = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) tx_done = 1'b1;
         end
         if (tx_start === 1'b1) begin
            r_nstart++;
            r_ts = c; d0 = tx_data; started = 1;
            cd = (dly > 0) ? dly : 0;
            tx_done = early;
         end else if (started && tx_data !== d0) begin
            r_stable = 0;
         end
         if (ack0 === 1'b1 || ack1 === 1'b1) begin
            r_ok = 1; r_a0 = ack0; r_a1 = ack1; r_data = tx_data; r_to = timeout_err; r_ta = c;
            $display("xfer: ack0=%0b ack1=%0b data=%h start@%0d ack@%0d timeout_err=%0b",
                     ack0, ack1, tx_data, r_ts, r_ta, timeout_err);
         end
      end
      tx_done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; loopback_enable = 0; req0 = 0; req1 = 0; data0 = '0; data1 = '0; tx_done = 0;
      repeat (3) step();
      n_checks++;
      if ({busy, tx_start, ack0, ack1, grant_id, timeout_err} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 000000", {busy, tx_start, ack0, ack1, grant_id, timeout_err});
      end
      n_checks++;
      if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", tx_data); end
      rst_n = 1'b1;
      step();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_single();
      loopback_enable = 0; req1 = 1; data1 = 8'hA5;
      sb.push_back('{1'b1, 8'hA5});
      run_xfer(10, 0);
      n_checks++;
      if (!r_ok) begin n_fail++; $display("FAIL single_ack: got no ack expected ack1"); end
      n_checks++;
      if (r_ts !== 1) begin n_fail++; $display("FAIL single_start_lat: got %0d expected 1", r_ts); end
      n_checks++;
      if (r_ta - r_ts !== 11) begin n_fail++; $display("FAIL single_ack_lat: got %0d expected 11", r_ta - r_ts); end
      n_checks++;
      if (r_nstart !== 1) begin n_fail++; $display("FAIL single_nstart: got %0d expected 1", r_nstart); end
      n_checks++;
      if (!r_stable) begin n_fail++; $display("FAIL single_stable: got unstable expected stable"); end
      e = sb.pop_front();
      n_checks++;
      if ({r_a1, r_a0, r_data, r_to} !== {e.src, ~e.src, e.data, 1'b0}) begin
         n_fail++;
         $display("FAIL single_sb: got a1=%b a0=%b d=%h to=%b expected src=%b d=%h to=0", r_a1, r_a0, r_data, r_to, e.src, e.data);
      end
      req1 = 0;
      step();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
   endtask

   task automatic test_round_robin();
      logic ml;
      int cnt0, cnt1;
      ml = 1'b1;  // last served was source 1
      cnt0 = 0; cnt1 = 0;
      loopback_enable = 0; data0 = 8'h11; data1 = 8'h22; req0 = 1; req1 = 1;
      for (int i = 0; i < 4; i++) begin
         ml = ~ml;
         sb.push_back('{ml, ml ? 8'h22 : 8'h11});
      end
      for (int i = 0; i < 4; i++) begin
         run_xfer(3, 0);
         n_checks++;
         if (r_ts !== ((i == 0) ? 1 : 2)) begin n_fail++; $display("FAIL rr_start_lat[%0d]: got %0d expected %0d", i, r_ts, (i == 0) ? 1 : 2); end
         if (sb.size() == 0) begin n_checks++; n_fail++; $display("FAIL rr_sb_empty[%0d]: got ack expected none", i); end
         else begin
            e = sb.pop_front();
            n_checks++;
            if (!r_ok || {r_a1, r_a0, r_data} !== {e.src, ~e.src, e.data}) begin
               n_fail++;
               $display("FAIL rr_sb[%0d]: got ok=%b a1=%b a0=%b d=%h expected src=%b d=%h", i, r_ok, r_a1, r_a0, r_data, e.src, e.data);
            end
         end
         if (r_a0 === 1'b1) cnt0++;
         if (r_a1 === 1'b1) cnt1++;
      end
      n_checks++;
      if (cnt0 != 2 || cnt1 != 2) begin n_fail++; $display("FAIL rr_fairness: got %0d/%0d expected 2/2", cnt0, cnt1); end
   endtask

   task automatic test_loopback();
      loopback_enable = 1;
      for (int i = 0; i < 3; i++) sb.push_back('{1'b0, 8'h11});
      for (int i = 0; i < 3; i++) begin
         run_xfer(3, 0);
         e = sb.pop_front();
         n_checks++;
         if (!r_ok || {r_a1, r_a0, r_data} !== {e.src, ~e.src, e.data}) begin
            n_fail++;
            $display("FAIL lb_sb[%0d]: got ok=%b a1=%b a0=%b d=%h expected src=%b d=%h", i, r_ok, r_a1, r_a0, r_data, e.src, e.data);
         end
      end
   endtask

   task automatic test_timeout();
      loopback_enable = 0; req1 = 0; data0 = 8'h3C;
      sb.push_back('{1'b0, 8'h3C});
      run_xfer(-1, 0);
      e = sb.pop_front();
      n_checks++;
      if (!r_ok || {r_a1, r_a0, r_data} !== {e.src, ~e.src, e.data}) begin
         n_fail++;
         $display("FAIL to_sb: got ok=%b a1=%b a0=%b d=%h expected src=%b d=%h", r_ok, r_a1, r_a0, r_data, e.src, e.data);
      end
      n_checks++;
      if (r_to !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b expected 1", r_to); end
      n_checks++;
      if (r_ta - r_ts !== 17) begin n_fail++; $display("FAIL to_lat: got %0d expected 17", r_ta - r_ts); end
      req0 = 0; req1 = 1; data1 = 8'h5A;
      sb.push_back('{1'b1, 8'h5A});
      step();
      n_checks++;
      if ({timeout_err, busy} !== 2'b00) begin n_fail++; $display("FAIL to_release: got %b expected 00", {timeout_err, busy}); end
      run_xfer(4, 0);
      e = sb.pop_front();
      n_checks++;
      if (!r_ok || r_ts !== 1 || r_to !== 1'b0 || {r_a1, r_a0, r_data} !== {e.src, ~e.src, e.data}) begin
         n_fail++;
         $display("FAIL to_next: got ok=%b ts=%0d to=%b a1=%b d=%h expected ts=1 to=0 src=%b d=%h", r_ok, r_ts, r_to, r_a1, r_data, e.src, e.data);
      end
   endtask

   task automatic test_reset_mid();
      data1 = 8'h77;
      repeat (4) step();
      n_checks++;
      if ({busy, grant_id} !== 2'b11) begin n_fail++; $display("FAIL rm_busy: got %b expected 11", {busy, grant_id}); end
      #4 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, tx_start, ack0, ack1, grant_id, timeout_err, tx_data} !== 14'b0) begin
         n_fail++;
         $display("FAIL rm_async: got %b expected 0", {busy, tx_start, ack0, ack1, grant_id, timeout_err, tx_data});
      end
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++;
         if ({ack0, ack1} !== 2'b00) begin n_fail++; $display("FAIL rm_noack[%0d]: got %b expected 00", i, {ack0, ack1}); end
      end
      rst_n = 1'b1;
      sb.push_back('{1'b1, 8'h77});
      run_xfer(3, 0);
      e = sb.pop_front();
      n_checks++;
      if (!r_ok || r_ts !== 1 || {r_a1, r_a0, r_data} !== {e.src, ~e.src, e.data}) begin
         n_fail++;
         $display("FAIL rm_fresh: got ok=%b ts=%0d a1=%b d=%h expected ts=1 src=%b d=%h", r_ok, r_ts, r_a1, r_data, e.src, e.data);
      end
   endtask

   task automatic test_done_edges();
      data1 = 8'hC3;
      sb.push_back('{1'b1, 8'hC3});
      run_xfer(5, 1);
      e = sb.pop_front();
      n_checks++;
      if (r_ta - r_ts !== 6) begin n_fail++; $display("FAIL de_start_done: got %0d expected 6", r_ta - r_ts); end
      n_checks++;
      if (!r_ok || r_to !== 1'b0 || {r_a1, r_a0, r_data} !== {e.src, ~e.src, e.data}) begin
         n_fail++;
         $display("FAIL de_sb0: got ok=%b to=%b a1=%b d=%h expected src=%b d=%h", r_ok, r_to, r_a1, r_data, e.src, e.data);
      end
      data1 = 8'h3D;
      sb.push_back('{1'b1, 8'h3D});
      run_xfer(16, 0);
      e = sb.pop_front();
      n_checks++;
      if (r_ta - r_ts !== 17) begin n_fail++; $display("FAIL de_last_lat: got %0d expected 17", r_ta - r_ts); end
      n_checks++;
      if (!r_ok || r_to !== 1'b0 || {r_a1, r_a0, r_data} !== {e.src, ~e.src, e.data}) begin
         n_fail++;
         $display("FAIL de_sb1: got ok=%b to=%b a1=%b d=%h expected to=0 src=%b d=%h", r_ok, r_to, r_a1, r_data, e.src, e.data);
      end
      req1 = 0;
      step();
      n_checks++;
      if ({busy, timeout_err} !== 2'b00) begin n_fail++; $display("FAIL de_idle: got %b expected 00", {busy, timeout_err}); end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_loopback();
      test_timeout();
      test_reset_mid();
      test_done_edges();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
